// File: rtl/pipe_ctrl.sv
// Pipeline control: stage enables/flushes, load-use and branch hazards, dmem freeze with timeout.
// Optional performance counters are enabled with `define PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_useRs1,
  input  logic       id_useRs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memRead,
  input  logic       ex_branchTaken,
  input  logic       me_memReq,
  input  logic       dmem_ack,
  output logic       dmem_req,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_me_en,
  output logic       me_wb_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_me_flush,
  output logic       me_wb_flush,
  output logic       mem_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state;
  logic [CW-1:0] wcnt;
  logic          freeze;
  logic          abort;
  logic          loadUse;
  logic          rs1Hit;
  logic          rs2Hit;

  assign rs1Hit  = id_useRs1 && (id_rs1 == ex_rd);
  assign rs2Hit  = id_useRs2 && (id_rs2 == ex_rd);
  assign loadUse = ex_memRead && (ex_rd != 5'd0) && (rs1Hit || rs2Hit);

  assign freeze = ((state == IDLE) && me_memReq && !dmem_ack)
               || ((state == WAIT) && !dmem_ack && (wcnt != LAST));
  assign abort  = (state == WAIT) && !dmem_ack && (wcnt == LAST);

  assign dmem_req    = (state == WAIT) || me_memReq;
  assign ex_me_flush = 1'b0;

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_me_en    = 1'b1;
    me_wb_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    me_wb_flush = 1'b0;
    if (freeze) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_me_en    = 1'b0;
      me_wb_flush = 1'b1;
    end else if (ex_branchTaken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (loadUse) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
    // aborted access must not write back
    if (abort) me_wb_flush = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      mem_err <= abort;
      case (state)
        IDLE: begin
          if (me_memReq && !dmem_ack) begin
            state <= WAIT;
            wcnt  <= '0;
          end
        end
        WAIT: begin
          if (dmem_ack || (wcnt == LAST)) state <= IDLE;
          else wcnt <= wcnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en) stall_cnt <= stall_cnt + 32'd1;
      if (if_id_flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (MEM_TIMEOUT=4).
// Perf counter checks are compiled in with PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       mq;
    logic       ack;
  } stim_t;

  // {req, pc, ifid, idex, exme, mewb, fIfid, fIdex, fExme, fMewb, err}
  localparam logic [10:0] O_IDLE  = 11'b0_11111_0000_0;
  localparam logic [10:0] O_LU    = 11'b0_00111_0100_0;
  localparam logic [10:0] O_BR    = 11'b0_11111_1100_0;
  localparam logic [10:0] O_FRZ   = 11'b1_00001_0001_0;
  localparam logic [10:0] O_REL   = 11'b1_11111_0000_0;
  localparam logic [10:0] O_ABT   = 11'b1_11111_0001_0;
  localparam logic [10:0] O_ERR   = 11'b0_11111_0000_1;
  localparam logic [10:0] O_RELBR = 11'b1_11111_1100_0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_useRs1 = 0, id_useRs2 = 0, ex_memRead = 0;
  logic ex_branchTaken = 0, me_memReq = 0, dmem_ack = 0;
  logic dmem_req, pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en;
  logic if_id_flush, id_ex_flush, ex_me_flush, me_wb_flush, mem_err;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [10:0] sb[$];

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_useRs1(id_useRs1), .id_useRs2(id_useRs2),
    .ex_rd(ex_rd), .ex_memRead(ex_memRead),
    .ex_branchTaken(ex_branchTaken),
    .me_memReq(me_memReq), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .pc_en(pc_en),
    .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_me_en(ex_me_en), .me_wb_en(me_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_me_flush(ex_me_flush), .me_wb_flush(me_wb_flush),
    .mem_err(mem_err)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  function automatic logic [10:0] outs();
    return {dmem_req, pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en,
            if_id_flush, id_ex_flush, ex_me_flush, me_wb_flush, mem_err};
  endfunction

  function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2,
                               input logic [4:0] rd, input logic mr,
                               input logic br, input logic mq,
                               input logic ack);
    stim_t s;
    s = '{rs1, rs2, u1, u2, rd, mr, br, mq, ack};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_useRs1 = s.u1; id_useRs2 = s.u2;
    ex_rd = s.rd; ex_memRead = s.mr;
    ex_branchTaken = s.br;
    me_memReq = s.mq; dmem_ack = s.ack;
  endtask

  task automatic drive(input stim_t s, input logic [10:0] e);
    @(posedge clk);
    #1;
    apply(s);
    sb.push_back(e);
  endtask

  task automatic test_reset();
    logic [10:0] e;
    rst = 1'b1;
    apply('0);
    #3;
    sb.push_back(O_IDLE);
    e = sb.pop_front();
    checks++;
    if (outs() !== e) begin
      failures++;
      $display("FAIL reset: got %b want %b", outs(), e);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_load_use();
    stim_t s[6];
    logic [10:0] x[6];
    logic [10:0] e;
    s[0] = mk(5, 0, 1, 0, 5, 1, 0, 0, 0); x[0] = O_LU;
    s[1] = mk(0, 0, 1, 0, 0, 1, 0, 0, 0); x[1] = O_IDLE;
    s[2] = mk(3, 7, 0, 1, 7, 1, 0, 0, 0); x[2] = O_LU;
    s[3] = mk(7, 0, 0, 0, 7, 1, 0, 0, 0); x[3] = O_IDLE;
    s[4] = mk(5, 0, 1, 0, 5, 0, 0, 0, 0); x[4] = O_IDLE;
    s[5] = mk(9, 9, 1, 1, 5, 1, 0, 0, 0); x[5] = O_IDLE;
    for (int i = 0; i < 6; i++) begin
      drive(s[i], x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (outs() !== e) begin
        failures++;
        $display("FAIL load_use[%0d]: got %b want %b", i, outs(), e);
      end
    end
  endtask

  task automatic test_branch();
    stim_t s[3];
    logic [10:0] x[3];
    logic [10:0] e;
    s[0] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0); x[0] = O_BR;
    s[1] = mk(5, 0, 1, 0, 5, 1, 1, 0, 0); x[1] = O_BR;
    s[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); x[2] = O_IDLE;
    for (int i = 0; i < 3; i++) begin
      drive(s[i], x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (outs() !== e) begin
        failures++;
        $display("FAIL branch[%0d]: got %b want %b", i, outs(), e);
      end
    end
  endtask

  task automatic test_slow_mem();
    stim_t s[6];
    logic [10:0] x[6];
    logic [10:0] e;
    for (int i = 0; i < 3; i++) begin
      s[i] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0); x[i] = O_FRZ;
    end
    s[3] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1); x[3] = O_REL;
    s[4] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1); x[4] = O_REL;
    s[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); x[5] = O_IDLE;
    for (int i = 0; i < 6; i++) begin
      drive(s[i], x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (outs() !== e) begin
        failures++;
        $display("FAIL slow_mem[%0d]: got %b want %b", i, outs(), e);
      end
    end
  endtask

  task automatic test_timeout();
    stim_t s[7];
    logic [10:0] x[7];
    logic [10:0] e;
    for (int i = 0; i < 4; i++) begin
      s[i] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0); x[i] = O_FRZ;
    end
    s[4] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0); x[4] = O_ABT;
    s[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); x[5] = O_ERR;
    s[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); x[6] = O_IDLE;
    for (int i = 0; i < 7; i++) begin
      drive(s[i], x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (outs() !== e) begin
        failures++;
        $display("FAIL timeout[%0d]: got %b want %b", i, outs(), e);
      end
    end
  endtask

  task automatic test_ack_at_timeout();
    stim_t s[6];
    logic [10:0] x[6];
    logic [10:0] e;
    for (int i = 0; i < 4; i++) begin
      s[i] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0); x[i] = O_FRZ;
    end
    s[4] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1); x[4] = O_REL;
    s[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); x[5] = O_IDLE;
    for (int i = 0; i < 6; i++) begin
      drive(s[i], x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (outs() !== e) begin
        failures++;
        $display("FAIL ack_at_timeout[%0d]: got %b want %b", i, outs(), e);
      end
    end
  endtask

  task automatic test_branch_in_freeze();
    stim_t s[4];
    logic [10:0] x[4];
    logic [10:0] e;
    s[0] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0); x[0] = O_FRZ;
    s[1] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0); x[1] = O_FRZ;
    s[2] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1); x[2] = O_RELBR;
    s[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); x[3] = O_IDLE;
    for (int i = 0; i < 4; i++) begin
      drive(s[i], x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (outs() !== e) begin
        failures++;
        $display("FAIL branch_in_freeze[%0d]: got %b want %b", i, outs(), e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [10:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), O_FRZ);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (outs() !== e) begin
        failures++;
        $display("FAIL async_pre[%0d]: got %b want %b", i, outs(), e);
      end
    end
    #2;
    rst = 1'b1;
    apply('0);
    sb.push_back(O_IDLE);
    #1;
    e = sb.pop_front();
    checks++;
    if (outs() !== e) begin
      failures++;
      $display("FAIL async_rst: got %b want %b", outs(), e);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive('0, O_IDLE);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (outs() !== e) begin
        failures++;
        $display("FAIL async_post[%0d]: got %b want %b", i, outs(), e);
      end
    end
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic test_perf();
    @(posedge clk);
    #1 rst = 1'b1;
    apply('0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), O_FRZ);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1), O_REL);
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), O_BR);
    drive('0, O_IDLE);
    @(negedge clk);
    sb.delete();
    checks++;
    if (stall_cnt !== 32'd3) begin
      failures++;
      $display("FAIL stall_cnt: got %0d want 3", stall_cnt);
    end
    checks++;
    if (flush_cnt !== 32'd1) begin
      failures++;
      $display("FAIL flush_cnt: got %0d want 1", flush_cnt);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_slow_mem();
    test_timeout();
    test_ack_at_timeout();
    test_branch_in_freeze();
    test_async_reset();
`ifdef PIPE_CTRL_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
